// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encodings, the ALU
// opcodes the sequencer issues on its own, and the queued command record.
package alu_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESULT  = 2'd3;

    typedef logic [1:0] seqState_t;

    localparam logic [2:0] OP_ARITH_BASE = 3'b101;
    localparam logic [2:0] OP_IDLE       = 3'b000;

    localparam int CMD_WIDTH = 20;

    typedef struct packed {
        logic        load;
        logic [2:0]  opcode;
        logic [15:0] operand;
    } aluCmd_t;

    function automatic logic isZero(input logic [15:0] value);
        return (value == 16'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO in front of the sequencer FSM; pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    iClock,
    input  logic    iResetn,
    input  logic    iPush,
    input  aluCmd_t iPushData,
    input  logic    iPop,
    output aluCmd_t oHead,
    output logic    oEmpty,
    output logic    oFull
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] count;
    aluCmd_t       mem [DEPTH];
    logic          doPush;
    logic          doPop;

    assign count  = wrPtr - rdPtr;
    assign oEmpty = (wrPtr == rdPtr);
    assign oFull  = (count == DEPTH_P);
    assign doPush = iPush && !oFull;
    assign doPop  = iPop && !oEmpty;
    assign oHead  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= iPushData;
                wrPtr              <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences queued commands through the external 16-bit ALU, keeping a running
// accumulator that feeds back as operand A and returning each result in order.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic        iCmdLoad,
    input  logic [2:0]  iCmdOpcode,
    input  logic [15:0] iCmdOperand,
    output logic [15:0] oAluA,
    output logic [15:0] oAluB,
    output logic [2:0]  oAluOpcode,
    input  logic [15:0] iAluAccumulator,
    input  logic        iAluCarry,
    input  logic        iAluZero,
    output logic        oResValid,
    input  logic        iResReady,
    output logic [15:0] oResData,
    output logic        oResCarry,
    output logic        oResZero,
    output logic        oBusy
);

    seqState_t   rState;
    logic [15:0] rAcc;
    logic [2:0]  rOpcode;
    logic [15:0] rOperand;
    logic [15:0] rResData;
    logic        rResCarry;
    logic        rResZero;

    aluCmd_t     pushCmd;
    aluCmd_t     headCmd;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        fifoPush;
    logic        fifoPop;

    assign pushCmd  = '{load: iCmdLoad, opcode: iCmdOpcode, operand: iCmdOperand};
    assign oCmdReady = !fifoFull;
    assign fifoPush  = iCmdValid && oCmdReady;
    assign fifoPop   = (rState == IDLE) && !fifoEmpty;

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) uCmdFifo (
        .iClock   (iClock),
        .iResetn  (iResetn),
        .iPush    (fifoPush),
        .iPushData(pushCmd),
        .iPop     (fifoPop),
        .oHead    (headCmd),
        .oEmpty   (fifoEmpty),
        .oFull    (fifoFull)
    );

    // Outside ISSUE/CAPTURE the ALU sees the logic opcode, which clears its carry flop.
    always_comb begin
        oAluB      = '0;
        oAluOpcode = OP_IDLE;
        if ((rState == ISSUE) || (rState == CAPTURE)) begin
            oAluB      = rOperand;
            oAluOpcode = rOpcode;
        end
    end

    assign oAluA     = rAcc;
    assign oResValid = (rState == RESULT);
    assign oResData  = rResData;
    assign oResCarry = rResCarry;
    assign oResZero  = rResZero;
    assign oBusy     = (rState != IDLE) || !fifoEmpty;

    // Flags are registered inside the ALU, so results are sampled one cycle after ISSUE.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            rState    <= IDLE;
            rAcc      <= '0;
            rOpcode   <= OP_IDLE;
            rOperand  <= '0;
            rResData  <= '0;
            rResCarry <= 1'b0;
            rResZero  <= 1'b0;
        end else begin
            case (rState)
                IDLE: begin
                    if (!fifoEmpty) begin
                        if (headCmd.load) begin
                            rAcc      <= headCmd.operand;
                            rResData  <= headCmd.operand;
                            rResCarry <= 1'b0;
                            rResZero  <= isZero(headCmd.operand);
                            rState    <= RESULT;
                        end else begin
                            rOpcode  <= headCmd.opcode;
                            rOperand <= headCmd.operand;
                            rState   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    rState <= CAPTURE;
                end
                CAPTURE: begin
                    rAcc      <= iAluAccumulator;
                    rResData  <= iAluAccumulator;
                    rResCarry <= iAluCarry;
                    rResZero  <= iAluZero;
                    rState    <= RESULT;
                end
                RESULT: begin
                    if (iResReady) begin
                        rState <= IDLE;
                    end
                end
                default: begin
                    rState <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU (registered flags)
// and hand-computed expected results.
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    logic        iClock = 1'b0;
    logic        iResetn = 1'b0;
    logic        iCmdValid = 1'b0;
    logic        oCmdReady;
    logic        iCmdLoad = 1'b0;
    logic [2:0]  iCmdOpcode = 3'b000;
    logic [15:0] iCmdOperand = 16'h0000;
    logic [15:0] oAluA;
    logic [15:0] oAluB;
    logic [2:0]  oAluOpcode;
    logic [15:0] aluAcc;
    logic        aluCarry;
    logic        aluZero;
    logic        oResValid;
    logic        iResReady = 1'b0;
    logic [15:0] oResData;
    logic        oResCarry;
    logic        oResZero;
    logic        oBusy;

    int checkCount = 0;
    int failCount  = 0;

    always #5 iClock = ~iClock;

    alu_sequencer #(
        .DEPTH(DEPTH)
    ) dut (
        .iClock         (iClock),
        .iResetn        (iResetn),
        .iCmdValid      (iCmdValid),
        .oCmdReady      (oCmdReady),
        .iCmdLoad       (iCmdLoad),
        .iCmdOpcode     (iCmdOpcode),
        .iCmdOperand    (iCmdOperand),
        .oAluA          (oAluA),
        .oAluB          (oAluB),
        .oAluOpcode     (oAluOpcode),
        .iAluAccumulator(aluAcc),
        .iAluCarry      (aluCarry),
        .iAluZero       (aluZero),
        .oResValid      (oResValid),
        .iResReady      (iResReady),
        .oResData       (oResData),
        .oResCarry      (oResCarry),
        .oResZero       (oResZero),
        .oBusy          (oBusy)
    );

    // Behavioural ALU: combinational result, carry and zero registered.
    logic [16:0] aluSum;
    assign aluSum = {1'b0, oAluA} + {1'b0, oAluB};

    always_comb begin
        case (oAluOpcode)
            3'b000:  aluAcc = oAluA & oAluB;
            3'b001:  aluAcc = oAluA | oAluB;
            3'b010:  aluAcc = oAluA ^ oAluB;
            3'b101:  aluAcc = aluSum[15:0];
            default: aluAcc = oAluB;
        endcase
    end

    always @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            aluCarry <= 1'b0;
            aluZero  <= 1'b0;
        end else begin
            aluCarry <= (oAluOpcode == 3'b101) ? aluSum[16] : 1'b0;
            aluZero  <= (aluAcc == 16'h0000);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic [2:0] opcode,
                                 input logic [15:0] operand);
        @(negedge iClock);
        iCmdValid   = 1'b1;
        iCmdLoad    = load;
        iCmdOpcode  = opcode;
        iCmdOperand = operand;
        @(posedge iClock);
        #1 iCmdValid = 1'b0;
    endtask

    // expLatency < 0 skips the latency comparison.
    task automatic consumeResult(input string tag, input int expLatency,
                                 input logic [15:0] expData, input logic expCarry,
                                 input logic expZero);
        int cycles;
        cycles = 0;
        while (!oResValid && cycles < 40) begin
            @(negedge iClock);
            cycles++;
        end
        checkOutput({tag, ".valid"}, 32'(oResValid), 32'd1);
        if (expLatency >= 0) checkOutput({tag, ".latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({tag, ".data"},  32'(oResData),  32'(expData));
        checkOutput({tag, ".carry"}, 32'(oResCarry), 32'(expCarry));
        checkOutput({tag, ".zero"},  32'(oResZero),  32'(expZero));
        iResReady = 1'b1;
        @(posedge iClock);
        #1 iResReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [19:0] t4Cmds [4];
        logic [15:0] t4Exp  [5];
        logic [15:0] t6Exp  [5];
        logic        t6Zero [5];
        int          seen;

        t4Cmds = '{20'h50002, 20'h50004, 20'h00005, 20'h88000};
        t4Exp  = '{16'h0001, 16'h0003, 16'h0007, 16'h0005, 16'h8000};
        t6Exp  = '{16'h0022, 16'h0033, 16'h0133, 16'h0030, 16'h0000};
        t6Zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        $display("[TB] reset state");
        repeat (3) @(negedge iClock);
        checkOutput("rst.resValid", 32'(oResValid), 32'd0);
        checkOutput("rst.resData",  32'(oResData),  32'd0);
        checkOutput("rst.aluA",     32'(oAluA),     32'd0);
        checkOutput("rst.aluB",     32'(oAluB),     32'd0);
        checkOutput("rst.aluOp",    32'(oAluOpcode), 32'd0);
        checkOutput("rst.cmdReady", 32'(oCmdReady), 32'd1);
        checkOutput("rst.busy",     32'(oBusy),     32'd0);
        iResetn = 1'b1;

        $display("[TB] loads");
        applyStimulus(1'b1, 3'b000, 16'h1234);
        consumeResult("t1.load1234", 2, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b000, 16'h0000);
        consumeResult("t1.load0000", 2, 16'h0000, 1'b0, 1'b1);

        $display("[TB] add with carry-out");
        applyStimulus(1'b1, 3'b000, 16'hFFFF);
        consumeResult("t2.loadFFFF", 2, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b101, 16'h0001);
        consumeResult("t2.add1", 4, 16'h0000, 1'b1, 1'b1);
        checkOutput("t2.aluA", 32'(oAluA), 32'h0000);

        $display("[TB] back-to-back load then AND");
        applyStimulus(1'b1, 3'b000, 16'h00F0);
        applyStimulus(1'b0, 3'b000, 16'h0FF0);
        consumeResult("t3.load00F0", -1, 16'h00F0, 1'b0, 1'b0);
        checkOutput("t3.idleOp",   32'(oAluOpcode), 32'd0);
        checkOutput("t3.idleB",    32'(oAluB),      32'd0);
        checkOutput("t3.idleA",    32'(oAluA),      32'h00F0);
        checkOutput("t3.idleBusy", 32'(oBusy),      32'd1);
        consumeResult("t3.and", -1, 16'h00F0, 1'b0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 3'b000, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(t4Cmds[i][19], t4Cmds[i][18:16], t4Cmds[i][15:0]);
            checkOutput($sformatf("t4.ready%0d", i), 32'(oCmdReady), 32'(i < DEPTH - 1));
        end
        @(negedge iClock);
        iCmdValid   = 1'b1;
        iCmdLoad    = 1'b1;
        iCmdOperand = 16'hDEAD;
        repeat (2) @(posedge iClock);
        #1;
        checkOutput("t4.blockedReady", 32'(oCmdReady), 32'd0);
        iCmdValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4.busy%0d", i), 32'(oBusy), 32'd1);
            consumeResult($sformatf("t4.res%0d", i), -1, t4Exp[i], 1'b0, 1'b0);
        end
        checkOutput("t4.busyLast", 32'(oBusy), 32'd0);
        seen = 0;
        repeat (4) begin
            @(negedge iClock);
            if (oResValid) seen++;
        end
        checkOutput("t4.noExtra", 32'(seen), 32'd0);

        $display("[TB] reset during CAPTURE");
        applyStimulus(1'b0, 3'b101, 16'h0001);
        applyStimulus(1'b1, 3'b000, 16'h1111);
        applyStimulus(1'b1, 3'b000, 16'h2222);
        @(negedge iClock);
        checkOutput("t5.captureOp", 32'(oAluOpcode), 32'h5);
        checkOutput("t5.captureB",  32'(oAluB),      32'h0001);
        checkOutput("t5.captureA",  32'(oAluA),      32'h8000);
        iResetn = 1'b0;
        #1;
        checkOutput("t5.rstValid", 32'(oResValid),  32'd0);
        checkOutput("t5.rstData",  32'(oResData),   32'd0);
        checkOutput("t5.rstA",     32'(oAluA),      32'd0);
        checkOutput("t5.rstB",     32'(oAluB),      32'd0);
        checkOutput("t5.rstOp",    32'(oAluOpcode), 32'd0);
        checkOutput("t5.rstReady", 32'(oCmdReady),  32'd1);
        checkOutput("t5.rstBusy",  32'(oBusy),      32'd0);
        repeat (2) @(negedge iClock);
        iResetn   = 1'b1;
        iResReady = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge iClock);
            if (oResValid) seen++;
        end
        iResReady = 1'b0;
        checkOutput("t5.noResult", 32'(seen), 32'd0);
        checkOutput("t5.idleBusy", 32'(oBusy), 32'd0);

        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, 3'b000, 16'h0011);
        applyStimulus(1'b1, 3'b000, 16'h0022);
        applyStimulus(1'b1, 3'b000, 16'h0033);
        consumeResult("t6.res0", -1, 16'h0011, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b101, 16'h0100);
        checkOutput("t6.readyAfterSwap", 32'(oCmdReady), 32'd1);
        applyStimulus(1'b0, 3'b000, 16'h00F0);
        checkOutput("t6.readyAt3", 32'(oCmdReady), 32'd1);
        applyStimulus(1'b1, 3'b000, 16'h0000);
        checkOutput("t6.readyAt4", 32'(oCmdReady), 32'd0);
        for (int i = 0; i < 5; i++) begin
            consumeResult($sformatf("t6.res%0d", i + 1), -1, t6Exp[i], 1'b0, t6Zero[i]);
        end
        checkOutput("t6.busyEnd", 32'(oBusy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command sequencer directly upstream of the 16-bit ALU. It buffers operation commands in a small FIFO, drives the ALU operands and opcode, and waits out the ALU's registered flag timing. It then captures the accumulator, carry and zero flag, and returns them on a valid/ready result port. The captured accumulator is fed back as operand A of the next command, so a stream of commands forms a running computation.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.

Ports:
- iClock  in  1  single clock, rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iCmdValid  in  1  command offered.
- oCmdReady  out  1  FIFO can accept; equals (count < DEPTH).
- iCmdLoad  in  1  1 = load operand into accumulator, no ALU operation.
- iCmdOpcode  in  3  ALU opcode; ignored when iCmdLoad = 1.
- iCmdOperand  in  16  operand B, or the load value.
- oAluA  out  16  to ALU iA; always the internal accumulator rAcc.
- oAluB  out  16  to ALU iB.
- oAluOpcode  out  3  to ALU iOpcode.
- iAluAccumulator  in  16  ALU result (combinational).
- iAluCarry  in  1  ALU carry flag (registered inside ALU).
- iAluZero  in  1  ALU zero flag (registered inside ALU).
- oResValid  out  1  result available.
- iResReady  in  1  result consumer ready.
- oResData  out  16  result value.
- oResCarry  out  1  result carry.
- oResZero  out  1  result zero.
- oBusy  out  1  1 whenever state ≠ IDLE or FIFO is non-empty.

## Operation
- Command accept: push on iCmdValid & oCmdReady, storing {load, opcode, operand}. Push and pop in the same cycle leaves count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESULT.
- IDLE:
  - Drives oAluOpcode = 3'b000 and oAluB = 0. The logic opcode clears the ALU carry flop, so every arithmetic command starts with carry 0.
  - FIFO non-empty: pop the head into the command register.
  - Load command → RESULT with result {operand, carry 0, zero = (operand == 0)}; rAcc ← operand.
  - ALU command → ISSUE.
- ISSUE: drive oAluA = rAcc, oAluB = operand, oAluOpcode = opcode. The ALU registers its flags at the end of this cycle. Next state: CAPTURE.
- CAPTURE:
  - Hold the same ALU inputs.
  - Sample iAluAccumulator, iAluCarry and iAluZero into the result registers.
  - rAcc ← iAluAccumulator.
  - Next state: RESULT.
- RESULT:
  - oResValid = 1 and ALU inputs revert to IDLE values.
  - oResData, oResCarry and oResZero stay stable until iResReady.
  - On handshake → IDLE.
- Logic opcodes (000–100) report carry as sampled from the ALU, which is 0 by ALU construction; no masking is applied here.
- Invalid state encodings → IDLE.

## Timing
- Reset values: all result outputs 0, oResValid 0, oAluA/oAluB 0, oAluOpcode 3'b000, rAcc 0, FIFO empty, oCmdReady 1, oBusy 0, state IDLE.
- Reset asserted mid-operation: the in-flight command and all FIFO contents are discarded; no result is produced.
- Latency from accept edge to oResValid:
  - ALU command: 4 cycles (FIFO write, IDLE pop, ISSUE, CAPTURE).
  - Load command: 2 cycles.
- Throughput: one ALU command per 4 cycles with iResReady held at 1; one load per 2 cycles.
- Result backpressure: the FIFO keeps accepting until full; oCmdReady drops the cycle count reaches DEPTH.
- Ordering: results leave strictly in command order.

## Structure
- Shared package alu_pkg:
  - State enum (IDLE/ISSUE/CAPTURE/RESULT).
  - OP_ARITH_BASE = 3'b101 and OP_IDLE = 3'b000.
  - Command record width (1 + 3 + 16 = 20).
- Sub-module alu_cmd_fifo:
  - Parameterised DEPTH × 20 bits.
  - Pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Reset under the same async active-low reset.
- Top level holds the FSM, rAcc and the result registers.

## Test plan
The bench uses a behavioural ALU model: 3'b101 = A+B with registered carry, 3'b000 = A&B, and a registered zero flag.
- Load 0x1234 → 2 cycles later oResData 0x1234, oResCarry 0, oResZero 0; then load 0x0000 → oResZero 1.
- Load 0xFFFF, then ALU 3'b101 with operand 0x0001 → oResData 0x0000, oResCarry 1, oResZero 1, 4 cycles after accept.
- Back-to-back load 0x00F0 then 3'b000 with operand 0x0FF0 → oResData 0x00F0, carry 0, zero 0; oAluOpcode reads 000 in IDLE between commands.
- Hold iResReady 0 and push DEPTH+1 commands → oCmdReady falls after the DEPTH-th accept. Release iResReady → all results emerge in order and oBusy falls last.
- Assert iResetn low during CAPTURE with 2 commands queued → all outputs reach reset values immediately and no result follows after release.
- Push and pop in the same cycle with count = 2 → count stays 2 and data order is preserved.
